// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder: format codes, opcodes,
// immediate range limits and the field-packing helper.
package inst_encoder_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'b000,
        IMM_S  = 3'b001,
        IMM_SB = 3'b010,
        IMM_U  = 3'b011,
        IMM_UJ = 3'b100
    } imm_type_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic signed [63:0] I_MIN  = -64'sd2048;
    localparam logic signed [63:0] I_MAX  =  64'sd2047;
    localparam logic signed [63:0] SB_MIN = -64'sd4096;
    localparam logic signed [63:0] SB_MAX =  64'sd4094;
    localparam logic signed [63:0] U_MIN  = -64'sd2147483648;
    localparam logic signed [63:0] U_MAX  =  64'sd2147483647;
    localparam logic signed [63:0] UJ_MIN = -64'sd1048576;
    localparam logic signed [63:0] UJ_MAX =  64'sd1048574;

    typedef struct packed {
        logic [2:0]  itype;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [63:0] imm;
    } inst_req_t;

    // Scatters register fields and immediate bits into the 32-bit word.
    // Legality is judged elsewhere; a reserved format simply yields a NOP.
    function automatic logic [31:0] pack_inst(input inst_req_t r);
        logic [31:0] w;
        w       = '0;
        w[6:0]  = r.opcode;
        case (r.itype)
            IMM_I: begin
                w[11:7]  = r.rd;
                w[14:12] = r.funct3;
                w[19:15] = r.rs1;
                w[31:20] = r.imm[11:0];
            end
            IMM_S: begin
                w[11:7]  = r.imm[4:0];
                w[14:12] = r.funct3;
                w[19:15] = r.rs1;
                w[24:20] = r.rs2;
                w[31:25] = r.imm[11:5];
            end
            IMM_SB: begin
                w[7]     = r.imm[11];
                w[11:8]  = r.imm[4:1];
                w[14:12] = r.funct3;
                w[19:15] = r.rs1;
                w[24:20] = r.rs2;
                w[30:25] = r.imm[10:5];
                w[31]    = r.imm[12];
            end
            IMM_U: begin
                w[11:7]  = r.rd;
                w[31:12] = r.imm[31:12];
            end
            IMM_UJ: begin
                w[11:7]  = r.rd;
                w[19:12] = r.imm[19:12];
                w[20]    = r.imm[11];
                w[30:21] = r.imm[10:1];
                w[31]    = r.imm[20];
            end
            default: w = NOP;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational legality check: immediate range/alignment per format,
// the format's permitted opcode, and reserved format codes.
module imm_range_check
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  itype,
    input  logic [6:0]  opcode,
    input  logic [63:0] imm,
    output logic        err
);

    logic signed [63:0] simm;
    logic               range_err;
    logic               op_err;

    assign simm = imm;

    // NOTE: every signal written here gets a default first so that no path
    // through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        range_err = 1'b0;
        op_err    = 1'b0;
        case (itype)
            IMM_I: begin
                range_err = (simm < I_MIN) || (simm > I_MAX);
                op_err    = !((opcode == OP_LOAD) || (opcode == OP_IMM));
            end
            IMM_S: begin
                range_err = (simm < I_MIN) || (simm > I_MAX);
                op_err    = (opcode != OP_STORE);
            end
            IMM_SB: begin
                range_err = (simm < SB_MIN) || (simm > SB_MAX) || imm[0];
                op_err    = (opcode != OP_BRANCH);
            end
            IMM_U: begin
                range_err = (imm[11:0] != 12'd0) || (simm < U_MIN) || (simm > U_MAX);
                op_err    = (opcode != OP_LUI);
            end
            IMM_UJ: begin
                range_err = (simm < UJ_MIN) || (simm > UJ_MAX) || imm[0];
                op_err    = (opcode != OP_JAL);
            end
            default: op_err = 1'b1;
        endcase
    end

    assign err = range_err || op_err;

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: one registered output stage with ready/valid
// handshaking, NOP substitution on illegal requests and an address counter.
module inst_encoder
    import inst_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [63:0] in_imm,
    input  logic        base_load,
    input  logic [63:0] base_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_addr,
    output logic        out_err,
    output logic [15:0] err_count
);

    inst_req_t   req;
    logic        accept;
    logic        req_err;
    logic [31:0] packed_inst;
    logic [63:0] addr_q;
    logic [63:0] addr_sel;
    logic        unused_funct7;

    // No supported format carries funct7; the field is accepted and ignored.
    assign unused_funct7 = ^in_funct7;

    assign req = '{itype:  in_type,
                   opcode: in_opcode,
                   rd:     in_rd,
                   rs1:    in_rs1,
                   rs2:    in_rs2,
                   funct3: in_funct3,
                   imm:    in_imm};

    // Nothing is accepted during reset so a request cannot race the clear.
    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // A simultaneous base load wins, and the accepted word takes the new base.
    assign addr_sel = base_load ? base_addr : addr_q;

    imm_range_check u_imm_range_check (
        .itype  (in_type),
        .opcode (in_opcode),
        .imm    (in_imm),
        .err    (req_err)
    );

    assign packed_inst = pack_inst(req);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_addr  <= '0;
            out_err   <= 1'b0;
            err_count <= '0;
            addr_q    <= '0;
        end else begin
            if (base_load || accept)
                addr_q <= addr_sel + (accept ? 64'd4 : 64'd0);

            if (accept) begin
                out_valid <= 1'b1;
                out_inst  <= req_err ? NOP : packed_inst;
                out_addr  <= addr_sel;
                out_err   <= req_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Errors are counted when the word leaves, not when it arrives.
            if (out_valid && out_ready && out_err && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: scoreboard of expected words,
// negedge monitor with hold-stability checks, one task per scenario.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [63:0] in_imm;
    logic        base_load;
    logic [63:0] base_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_addr;
    logic        out_err;
    logic [15:0] err_count;

    inst_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .base_load(base_load), .base_addr(base_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] addr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          popped = 0;
    logic [63:0] exp_addr = '0;
    int          exp_errs = 0;

    // Reference encoder: legality judged on the signed value, fields concatenated.
    function automatic logic [32:0] model(input logic [2:0] t, input logic [6:0] op,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3,
                                          input logic [63:0] imm);
        longint      v;
        logic [63:0] u;
        logic        bad;
        logic [31:0] w;
        v = longint'(imm);
        u = imm;
        bad = 1'b0;
        w = 32'h0;
        case (t)
            3'd0: begin bad = v < -2048 || v > 2047 || !(op == 7'h03 || op == 7'h13);
                        w = {u[11:0], rs1, f3, rd, op}; end
            3'd1: begin bad = v < -2048 || v > 2047 || op != 7'h23;
                        w = {u[11:5], rs2, rs1, f3, u[4:0], op}; end
            3'd2: begin bad = v < -4096 || v > 4094 || u[0] || op != 7'h63;
                        w = {u[12], u[10:5], rs2, rs1, f3, u[4:1], u[11], op}; end
            3'd3: begin bad = (u[11:0] != 12'h0) || v < -64'sd2147483648 || v > 64'sd2147483647 || op != 7'h37;
                        w = {u[31:12], rd, op}; end
            3'd4: begin bad = v < -1048576 || v > 1048574 || u[0] || op != 7'h6F;
                        w = {u[20], u[10:1], u[11], u[19:12], rd, op}; end
            default: bad = 1'b1;
        endcase
        return {bad, bad ? 32'h0000_0013 : w};
    endfunction

    // Monitor: compares each transferred word and checks held words stay put.
    logic [31:0] h_inst;
    logic [63:0] h_addr;
    logic        h_err;
    logic        h_stall = 1'b0;
    exp_t        e;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            h_stall = 1'b0;
        end else begin
            if (h_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_inst !== h_inst || out_addr !== h_addr || out_err !== h_err) begin
                    miscompares++;
                    $display("FAIL hold_stable: got valid=%b inst=%h addr=%h err=%b, required valid=1 inst=%h addr=%h err=%b",
                             out_valid, out_inst, out_addr, out_err, h_inst, h_addr, h_err);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: got inst=%h addr=%h with empty scoreboard", out_inst, out_addr);
                end else begin
                    e = sb.pop_front();
                    popped++;
                    if (out_inst !== e.inst || out_addr !== e.addr || out_err !== e.err) begin
                        miscompares++;
                        $display("FAIL word: got inst=%h addr=%h err=%b, required inst=%h addr=%h err=%b",
                                 out_inst, out_addr, out_err, e.inst, e.addr, e.err);
                    end
                end
            end
            h_stall = (out_valid === 1'b1 && out_ready === 1'b0);
            h_inst  = out_inst;
            h_addr  = out_addr;
            h_err   = out_err;
        end
    end

    // Drives one request from posedge+1 until accepted; returns at posedge+1 after acceptance.
    task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [63:0] imm, input logic [31:0] x_inst, input logic x_err,
                        input logic bl, input logic [63:0] ba);
        bit done;
        exp_t x;
        done = 0;
        in_valid = 1'b1; in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_funct3 = f3; in_imm = imm; in_funct7 = 7'h55;
        base_load = bl; base_addr = ba;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                x.inst = x_inst;
                x.addr = bl ? ba : exp_addr;
                x.err  = x_err;
                sb.push_back(x);
                exp_addr = x.addr + 64'd4;
                if (x_err) exp_errs++;
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        base_load = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got in_ready never high, required acceptance within 100 cycles");
        end
    endtask

    task automatic send_model(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [63:0] imm);
        logic [32:0] m;
        m = model(t, op, rd, rs1, rs2, f3, imm);
        send(t, op, rd, rs1, rs2, f3, imm, m[31:0], m[32], 1'b0, 64'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d words outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_err_count();
        vectors++;
        if (err_count !== 16'(exp_errs)) begin
            miscompares++;
            $display("FAIL err_count: got %0d, required %0d", err_count, exp_errs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; base_load = 1'b0; base_addr = '0; out_ready = 1'b1;
        in_type = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_inst !== 32'h0 || out_addr !== 64'h0 ||
            out_err !== 1'b0 || err_count !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b valid=%b inst=%h addr=%h err=%b cnt=%h, required all 0",
                     in_ready, out_valid, out_inst, out_addr, out_err, err_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_i_type();
        send(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 64'd5, 32'h0050_0093, 1'b0, 1'b0, 64'h0);
        vectors++;
        if (out_valid !== 1'b1 || out_inst !== 32'h0050_0093) begin
            miscompares++;
            $display("FAIL i_latency: got valid=%b inst=%h one cycle after accept, required valid=1 inst=00500093",
                     out_valid, out_inst);
        end
        drain();
    endtask

    task automatic test_s_sb();
        send(3'b001, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 64'd8, 32'h0020_A423, 1'b0, 1'b0, 64'h0);
        send(3'b010, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, -64'sd4, 32'hFE20_8EE3, 1'b0, 1'b0, 64'h0);
        drain();
    endtask

    task automatic test_u_uj();
        send(3'b011, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 64'h1234_5000, 32'h1234_52B7, 1'b0, 1'b0, 64'h0);
        send(3'b100, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, -64'sd8, 32'hFF9F_F06F, 1'b0, 1'b0, 64'h0);
        drain();
    endtask

    task automatic test_errors();
        send(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 64'd2048, 32'h0000_0013, 1'b1, 1'b0, 64'h0);
        drain();
        check_err_count();
        send(3'b010, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 64'd3, 32'h0000_0013, 1'b1, 1'b0, 64'h0);
        send(3'b111, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 64'd0, 32'h0000_0013, 1'b1, 1'b0, 64'h0);
        send(3'b001, 7'b0010011, 5'd0, 5'd1, 5'd2, 3'b000, 64'd0, 32'h0000_0013, 1'b1, 1'b0, 64'h0);
        drain();
        check_err_count();
    endtask

    task automatic test_boundaries();
        send_model(3'd0, 7'h03, 5'd3, 5'd4, 5'd0, 3'd2, -64'sd2048);
        send_model(3'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0,  64'sd2047);
        send_model(3'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, -64'sd2049);
        send_model(3'd1, 7'h23, 5'd0, 5'd6, 5'd7, 3'd3,  64'sd2048);
        send_model(3'd2, 7'h63, 5'd0, 5'd6, 5'd7, 3'd1,  64'sd4094);
        send_model(3'd2, 7'h63, 5'd0, 5'd6, 5'd7, 3'd1, -64'sd4096);
        send_model(3'd2, 7'h63, 5'd0, 5'd6, 5'd7, 3'd1,  64'sd4096);
        send_model(3'd3, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0,  64'h0000_0000_7FFF_F000);
        send_model(3'd3, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0,  64'hFFFF_FFFF_8000_0000);
        send_model(3'd3, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0,  64'h0000_0000_8000_0000);
        send_model(3'd3, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0,  64'h0000_0000_0000_1800);
        send_model(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0,  64'sd1048574);
        send_model(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, -64'sd1048576);
        send_model(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0,  64'sd1048576);
        send_model(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0,  64'sd7);
        drain();
        check_err_count();
    endtask

    task automatic test_back_to_back();
        int start;
        base_load = 1'b1; base_addr = 64'h1000; in_valid = 1'b0;
        @(posedge clk); #1;
        base_load = 1'b0;
        exp_addr = 64'h1000;
        out_ready = 1'b0;
        start = popped;
        fork
            begin
                send(3'b000, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 64'd1, 32'h0011_0093, 1'b0, 1'b0, 64'h0);
                send(3'b000, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 64'd2, 32'h0021_0113, 1'b0, 1'b0, 64'h0);
                send(3'b000, 7'h13, 5'd3, 5'd2, 5'd0, 3'd0, 64'd3, 32'h0031_0193, 1'b0, 1'b0, 64'h0);
            end
            begin
                @(posedge clk);
                @(negedge clk);
                vectors++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_ready: got in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
                end
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        vectors++;
        if (popped - start != 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d words, required 3", popped - start);
        end
    endtask

    task automatic test_base_priority();
        send(3'b011, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 64'h0000_1000, 32'h0000_1137, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        send(3'b011, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 64'h0000_2000, 32'h0000_2137, 1'b0, 1'b0, 64'h0);
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 64'd5, 32'h0050_0093, 1'b0, 1'b0, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_cycle: got in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || out_addr !== 64'h0 || err_count !== 16'h0) begin
            miscompares++;
            $display("FAIL rst_mid: got valid=%b addr=%h cnt=%h, required 0/0/0", out_valid, out_addr, err_count);
        end
        rst = 1'b0;
        sb.delete();
        exp_addr = 64'h0;
        exp_errs = 0;
        out_ready = 1'b1;
        send(3'b000, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 64'd1, 32'h0010_0393, 1'b0, 1'b0, 64'h0);
        drain();
    endtask

    initial begin
        test_reset();
        test_i_type();
        test_s_sb();
        test_u_uj();
        test_errors();
        test_boundaries();
        test_back_to_back();
        test_base_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have the following ports, one per line (name, direction, width, meaning); clock and reset come first.
  clk  in  1  single clock, rising edge.
  rst  in  1  reset; synchronous and active-high.
  in_valid  in  1  request valid.
  in_ready  out  1  request accepted when in_valid&&in_ready.
  in_type  in  3  format: 000 I, 001 S, 010 SB, 011 U, 100 UJ; 101-111 reserved.
  in_opcode  in  7  major opcode.
  in_rd, in_rs1, in_rs2  in  5 each  register fields.
  in_funct3  in  3  funct3 field.
  in_funct7  in  7  funct7 field (unused by I/S/SB/U/UJ; reserved).
  in_imm  in  64  signed byte immediate.
  base_load  in  1  load address counter.
  base_addr  in  64  new counter value.
  out_valid  out  1  output word valid.
  out_ready  in  1  consumer accepts the word.
  out_inst  out  32  encoded instruction.
  out_addr  out  64  write address for out_inst.
  out_err  out  1  word is a substituted NOP due to an error.
  err_count  out  16  saturating count of error words.

Function
REQ-002 SHALL be a single output register stage: in_ready = !out_valid || out_ready; latency 1 cycle from acceptance to out_valid.
REQ-003 SHALL hold out_inst, out_addr and out_err stable while out_valid && !out_ready.
REQ-004 SHALL pack fields as: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], as applicable to each format.
REQ-005 SHALL pack the I-type immediate as imm[11:0] into inst[31:20].
REQ-006 SHALL pack the S-type immediate as imm[11:5] into inst[31:25] and imm[4:0] into inst[11:7].
REQ-007 SHALL pack the SB-type immediate as imm[12] into inst[31], imm[10:5] into [30:25], imm[4:1] into [11:8] and imm[11] into [7].
REQ-008 SHALL pack the U-type immediate as imm[31:12] into inst[31:12].
REQ-009 SHALL pack the UJ-type immediate as imm[20] into inst[31], imm[10:1] into [30:21], imm[11] into [20] and imm[19:12] into [19:12].
REQ-010 SHALL flag an error for an immediate out of range:
  I/S outside [-2048, 2047];
  SB outside [-4096, 4094] or odd;
  U with imm[11:0] != 0 or outside the signed 32-bit range;
  UJ outside [-2^20, 2^20-2] or odd.
REQ-011 SHALL flag an error for a reserved in_type, or when in_opcode is not the format's legal opcode:
  I: 0000011 or 0010011
  S: 0100011
  SB: 1100011
  U: 0110111
  UJ: 1101111
REQ-012 SHALL, on error, emit out_inst = 0x00000013 (NOP) with out_err = 1.
REQ-013 SHALL increment err_count once per error word transferred, saturating at 0xFFFF.
REQ-014 SHALL set out_addr to the address counter value at acceptance; the counter increments by 4 per accepted request, error words included.
REQ-015 SHALL load the counter from base_addr on base_load; base_load has priority over a simultaneous acceptance, and the accepted word takes base_addr.
REQ-016 SHALL wrap the address counter modulo 2^64.

Reset
REQ-017 SHALL, while rst = 1 on a clock edge, clear to 0: out_valid, out_inst, out_addr, out_err, err_count and the address counter.
REQ-018 SHALL discard any held word when rst is asserted mid-transfer; in_ready = 0 during the rst cycle.

Structure
REQ-019 SHALL place the imm_type codes (000-100), the opcode constants, NOP = 0x00000013 and the format range limits in a shared package also used by the decode stage.
REQ-020 SHALL place range and opcode checking in one combinational sub-module, imm_range_check, outputting a single err bit.

Verification
REQ-021 I-type: in_type=000, opcode 0010011, rd=1, rs1=0, f3=000, imm=5 -> out_inst 0x00500093, out_err 0, 1 cycle later.
REQ-022 S and SB types:
  S: opcode 0100011, rs1=1, rs2=2, f3=010, imm=8 -> 0x0020A423.
  SB: opcode 1100011, rs1=1, rs2=2, f3=000, imm=-4 -> 0xFE208EE3.
REQ-023 U and UJ types:
  U: opcode 0110111, rd=5, imm=0x12345000 -> 0x123452B7.
  UJ: opcode 1101111, rd=0, imm=-8 -> 0xFF9FF06F.
REQ-024 Errors:
  I-type with imm=2048 -> 0x00000013, out_err 1, err_count 1.
  SB-type with imm=3 -> error.
  in_type=111 -> error.
REQ-025 Backpressure and addressing: base_load with base_addr=0x1000, then 3 back-to-back requests with out_ready low for 2 cycles -> words held stable, out_addr 0x1000/0x1004/0x1008, no loss or duplication.
REQ-026 Reset mid-transfer: rst asserted while out_valid=1 and out_ready=0 -> out_valid 0 next cycle; counter 0; next word has out_addr 0.
